// File: rtl/rr_load_arb.sv
// rtl/rr_load_arb.sv - round-robin arbiter loading a shared register with a per-grant hold window
module rr_load_arb #(
  parameter int W    = 8,
  parameter int HOLD = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [3:0]     REQ,
  input  logic [4*W-1:0] D,
  input  logic           INH,
  output logic [W-1:0]   Q,
  output logic [3:0]     GNT,
  output logic           ACK,
  output logic           BUSY
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       decide;

  // First requester at or after ptr, wrapping modulo 4.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign decide = ((state == S_IDLE) || (cnt == 4'd0)) && !INH && (REQ != 4'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      Q     <= '0;
      GNT   <= 4'd0;
      ACK   <= 1'b0;
      BUSY  <= 1'b0;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
    end else if (decide) begin
      Q     <= D[int'(win)*W +: W];
      GNT   <= 4'd1 << win;
      ACK   <= 1'b1;
      BUSY  <= 1'b1;
      ptr   <= win + 2'd1;
      cnt   <= 4'(HOLD - 1);
      state <= S_HOLD;
    end else if (state == S_HOLD && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      ACK <= 1'b0;
    end else if (state == S_HOLD) begin
      // Hold window expired with nobody eligible: release the grant, keep Q.
      state <= S_IDLE;
      GNT   <= 4'd0;
      BUSY  <= 1'b0;
      ACK   <= 1'b0;
    end else begin
      ACK <= 1'b0;
    end
  end

endmodule
